assoc_cache: RTL
================

// Module: assoc_cache
// PURPOSE
//  Two-way set-associative, write-back, write-allocate data cache between the
//  CPU load/store port and a Wishbone B3 bus using incrementing bursts.
//  Successor to the direct-mapped cache, with parametrised line length and set
//  count. Per-set LRU replacement lets two colliding lines stay resident.
// PARAMETERS
//  WORDS_PER_LINE  8    32-bit words per line; power of two, >=2
//  NUM_SETS        256  sets per way; power of two
//  Derived: OFS=log2(WORDS_PER_LINE)+2, IDX=log2(NUM_SETS), TAG=32-OFS-IDX
// PORTS
//  clock_i         in   1   single clock, all state updates on rising edge
//  reset_i         in   1   synchronous, active-high reset
//  address_i       in   32  CPU byte address (bits[1:0] ignored)
//  read_enable_i   in   1   CPU read request
//  write_enable_i  in   1   CPU write request (never both with read)
//  cache_select_i  in   4   byte lane enables for writes; bit0 = bits[7:0]
//  cached_data_i   in   32  CPU write data
//  cached_data_o   out  32  read data of the hit word (combinational)
//  ready_o         out  1   request complete this cycle
//  adr_o           out  32  Wishbone address, word aligned
//  dat_i           in   32  Wishbone read data
//  dat_o           out  32  Wishbone write data
//  cyc_o, stb_o    out  1   Wishbone cycle / strobe (always equal)
//  we_o            out  1   1 = write-back burst, 0 = fill burst
//  ack_i           in   1   Wishbone acknowledge
//  cti_o           out  3   010 incrementing burst, 111 last beat, 000 idle
// BEHAVIOUR
//  Reset: all valid, dirty and LRU bits cleared; cyc_o=stb_o=we_o=0;
//   cti_o=000; adr_o=0; dat_o=0; state IDLE. Data RAM is not cleared.
//   Reset mid-burst drops cyc_o/stb_o on the next edge; burst abandoned.
//  Lookup (IDLE, combinational): hit = valid & tag match in either way.
//   Read hit: ready_o=1, cached_data_o valid in the same cycle, no edge needed.
//   Write hit: ready_o=1. On the edge, byte lanes selected by cache_select_i
//   are merged into the word, and the line is marked dirty.
//   Any hit makes that way MRU. No request: ready_o=0, no state change.
//  Victim on miss: first invalid way (way 0 preferred), else LRU way.
//  States: IDLE -> WRITEBACK (victim valid & dirty) or FILL (otherwise);
//   WRITEBACK -> FILL after its last ack; FILL -> IDLE after its last ack.
//  The line base address is latched at miss detection. Changing address_i
//   mid-burst does not alter the burst. The new address is looked up in IDLE.
//  Burst timing: the edge that leaves IDLE asserts cyc_o/stb_o.
//   adr_o = line base, incremented by 4 on each edge with ack_i=1.
//   cti_o=010 until the final beat is pending, then cti_o=111.
//   Wait states (ack_i=0) hold adr_o, dat_o and cti_o stable.
//   The edge taking the final ack clears cyc_o/stb_o/we_o and sets cti_o=000.
//   WRITEBACK -> FILL re-asserts cyc_o on the next edge, so there is one idle
//   cycle between the two bursts.
//  WRITEBACK: we_o=1; dat_o = victim word at adr_o offset, updated after each
//   ack. After the last ack the dirty bit is cleared.
//  FILL: we_o=0; dat_i is written to the victim word at each ack. After the
//   last ack: tag written, valid=1, dirty=0, way becomes MRU.
//   Back in IDLE the request then hits. A write miss therefore completes one
//   edge after the fill.
//  Latency with zero wait states: clean miss = 1 + WORDS_PER_LINE edges;
//   dirty miss = 2 + 2*WORDS_PER_LINE edges.
//  ready_o=0 whenever state != IDLE.
// TESTING (defaults; set stride 0x2000)
//  1. Read 0x20, memory returns address as data -> one 8-beat fill at 0x20.
//     cti_o=010 x7 then 111. cached_data_o=0x20; read 0x24 -> 0x24, no bus cycle.
//  2. Read 0x20, then 0x2020, then 0x20 again -> second read fills way 1,
//     third read hits with no bus cycle. Read 0x4020 evicts 0x2020 (LRU),
//     with no write-back.
//  3. Write 0xcafebabe to 0x40 (hit), then read 0x2040 and 0x4040 ->
//     write-back burst of line 0x40 (we_o=1, dat_o word0=0xcafebabe),
//     then fill of 0x4040.
//  4. Write 0xaabbccdd, then single-lane writes 0x99/0x88/0x77/0x66 with
//     cache_select_i 0001/0010/0100/1000 -> read returns 0x66778899.
//  5. Fill with one wait state per beat and address_i changed to 0xC0 after
//     the first ack -> burst at 0x80 completes unchanged, then 0xC0 is filled.
//  6. Assert reset_i during beat 3 of a fill -> cyc_o=0 next edge.
//     Re-reading the same line refetches all 8 beats.

Source files
------------

// File: rtl/assoc_cache.sv
// assoc_cache: two-way set-associative write-back/write-allocate cache, Wishbone B3 burst master.
// Latency: hits complete combinationally; clean miss 1+WORDS_PER_LINE edges, dirty miss 2+2*WORDS_PER_LINE.
// Backpressure: ready_o stays low while a burst runs; ack_i wait states stall the burst in place.
module assoc_cache #(
  parameter int WORDS_PER_LINE = 8,
  parameter int NUM_SETS       = 256
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] address_i,
  input  logic        read_enable_i,
  input  logic        write_enable_i,
  input  logic [3:0]  cache_select_i,
  input  logic [31:0] cached_data_i,
  output logic [31:0] cached_data_o,
  output logic        ready_o,
  output logic [31:0] adr_o,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i,
  output logic [2:0]  cti_o
);
  localparam int WB  = $clog2(WORDS_PER_LINE);
  localparam int OFS = WB + 2;
  localparam int IDX = $clog2(NUM_SETS);
  localparam int TAG = 32 - OFS - IDX;
  localparam logic [WB-1:0] LAST = WB'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, GAP, FILL} state_t;
  typedef struct packed {
    logic [TAG-1:0] tag;
    logic [IDX-1:0] idx;
    logic           way;
  } miss_t;

  state_t         state, state_n;
  miss_t          miss_q;
  logic [WB-1:0]  beat, beat_inc;

  logic [31:0]    data_mem [2][WORDS_PER_LINE*NUM_SETS];
  logic [TAG-1:0] tag_mem  [2][NUM_SETS];
  logic [1:0][NUM_SETS-1:0] valid, dirty;
  logic [NUM_SETS-1:0]      lru;  // lru[s] is the way to replace next in set s

  logic [TAG-1:0] req_tag;
  logic [IDX-1:0] req_idx;
  logic [WB-1:0]  req_word;
  logic           hit0, hit1, hit_way, request, miss;
  logic           victim_way, victim_dirty, beat_ack, last_ack;
  logic [31:0]    merged;
  logic           unused_lsb;

  assign req_tag    = address_i[31:OFS+IDX];
  assign req_idx    = address_i[OFS+IDX-1:OFS];
  assign req_word   = address_i[OFS-1:2];
  assign unused_lsb = ^address_i[1:0];

  assign hit0    = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign hit1    = valid[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign hit_way = hit1;
  assign request = read_enable_i | write_enable_i;
  assign ready_o = (state == IDLE) && request && (hit0 | hit1);
  assign miss    = (state == IDLE) && request && !(hit0 | hit1);

  assign cached_data_o = data_mem[hit_way][{req_idx, req_word}];

  assign victim_way   = !valid[0][req_idx] ? 1'b0 :
                        (!valid[1][req_idx] ? 1'b1 : lru[req_idx]);
  assign victim_dirty = valid[victim_way][req_idx] & dirty[victim_way][req_idx];

  assign beat_ack = cyc_o & ack_i;
  assign last_ack = beat_ack && (beat == LAST);
  assign beat_inc = beat + WB'(1);
  assign stb_o    = cyc_o;

  always_comb begin
    merged = cached_data_o;
    for (int b = 0; b < 4; b++)
      if (cache_select_i[b]) merged[8*b +: 8] = cached_data_i[8*b +: 8];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (miss) state_n = victim_dirty ? WRITEBACK : FILL;
      WRITEBACK: if (last_ack) state_n = GAP;
      GAP:       state_n = FILL;
      FILL:      if (last_ack) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid  <= '0;
      dirty  <= '0;
      lru    <= '0;
      cyc_o  <= 1'b0;
      we_o   <= 1'b0;
      cti_o  <= 3'b000;
      adr_o  <= '0;
      dat_o  <= '0;
      beat   <= '0;
      miss_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ready_o) begin
            lru[req_idx] <= ~hit_way;
            if (write_enable_i) dirty[hit_way][req_idx] <= 1'b1;
          end else if (miss) begin
            miss_q.tag <= req_tag;
            miss_q.idx <= req_idx;
            miss_q.way <= victim_way;
            cyc_o      <= 1'b1;
            cti_o      <= 3'b010;
            beat       <= '0;
            we_o       <= victim_dirty;
            adr_o      <= victim_dirty ? {tag_mem[victim_way][req_idx], req_idx, {OFS{1'b0}}}
                                       : {req_tag, req_idx, {OFS{1'b0}}};
            dat_o      <= data_mem[victim_way][{req_idx, {WB{1'b0}}}];
          end
        end
        GAP: begin
          cyc_o <= 1'b1;
          we_o  <= 1'b0;
          cti_o <= 3'b010;
          beat  <= '0;
          adr_o <= {miss_q.tag, miss_q.idx, {OFS{1'b0}}};
        end
        default: begin
          if (beat_ack) begin
            beat  <= beat_inc;
            adr_o <= adr_o + 32'd4;
            if (state == WRITEBACK) dat_o <= data_mem[miss_q.way][{miss_q.idx, beat_inc}];
            if (beat == LAST) begin
              cyc_o <= 1'b0;
              we_o  <= 1'b0;
              cti_o <= 3'b000;
              dirty[miss_q.way][miss_q.idx] <= 1'b0;
              if (state == FILL) begin
                valid[miss_q.way][miss_q.idx] <= 1'b1;
                lru[miss_q.idx]               <= ~miss_q.way;
              end
            end else if (beat_inc == LAST) begin
              cti_o <= 3'b111;
            end
          end
        end
      endcase
    end
  end

  // Arrays are never cleared; tag/valid only become meaningful once a fill completes.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if (ready_o && write_enable_i)
        data_mem[hit_way][{req_idx, req_word}] <= merged;
      if (state == FILL && beat_ack)
        data_mem[miss_q.way][{miss_q.idx, beat}] <= dat_i;
      if (state == FILL && last_ack)
        tag_mem[miss_q.way][miss_q.idx] <= miss_q.tag;
    end
  end

endmodule
